// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ACCESS, DONE)
//   owner_e     : which CPU port owns the current access (fetch or data)
//   CNT_W       : width of the access-cycle counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection for mem_arbiter.
// Grants are only issued in IDLE; at most one grant is high.
// Build option: MEM_ARB_RR_EN selects round-robin on ties (the port not
// granted last wins); otherwise data always beats fetch.
//   if_req, dm_req : port requests
//   last_owner     : owner of the previous transfer (ignored in fixed mode)
//   state          : current arbiter state
//   if_gnt, dm_gnt : grants
//   winner         : owner that a transfer this cycle would latch
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  owner_e     last_owner,
  input  arb_state_e state,
  output logic       if_gnt,
  output logic       dm_gnt,
  output owner_e     winner
);

  logic idle;
  logic pick_dm;

  assign idle = (state == ARB_IDLE);

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the port to whoever did not have it last time.
  always_comb begin
    pick_dm = dm_req;
    if (dm_req && if_req) begin
      pick_dm = (last_owner == OWN_IF);
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWN_DM);
  assign pick_dm = dm_req;
`endif

  assign dm_gnt = idle & dm_req & pick_dm;
  assign if_gnt = idle & if_req & ~pick_dm;
  assign winner = pick_dm ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between the CPU
// instruction-fetch port (read-only) and the data-memory port. One access at
// a time: transfer in IDLE, MEM_LAT cycles of ACCESS, one DONE cycle with a
// done pulse to the owner, then back to IDLE.
// Build option: MEM_ARB_RR_EN enables round-robin tie breaking.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   if_req/if_addr            : fetch request (always a read)
//   if_gnt/if_done/if_rdata   : fetch grant (comb), done pulse, read data
//   dm_req/dm_wr/dm_addr/dm_wdata : data request
//   dm_gnt/dm_done/dm_rdata   : data grant (comb), done pulse, read data
//   mem_en/mem_wr/mem_addr/mem_wdata : memory port, zero outside ACCESS
//   mem_rdata                 : memory read data, valid in last ACCESS cycle
//   busy                      : state is not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  owner_e            owner_q;
  logic              mem_en_q, mem_wr_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_done_q, dm_done_q;

  logic   if_gnt_w, dm_gnt_w;
  owner_e winner_w;
  owner_e last_owner_w;

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q;

  // Resets to fetch so that data wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= OWN_IF;
    end else if (if_gnt_w || dm_gnt_w) begin
      last_owner_q <= winner_w;
    end
  end

  assign last_owner_w = last_owner_q;
`else
  assign last_owner_w = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner_w),
    .state      (state_q),
    .if_gnt     (if_gnt_w),
    .dm_gnt     (dm_gnt_w),
    .winner     (winner_w)
  );

  // The memory-port registers double as the latched request fields: they
  // are loaded at the transfer and cleared when ACCESS ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (if_gnt_w || dm_gnt_w) begin
            state_q  <= ARB_ACCESS;
            cnt_q    <= '0;
            owner_q  <= winner_w;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            if (winner_w == OWN_DM) begin
              mem_addr_q  <= dm_addr;
              mem_wr_q    <= dm_wr;
              mem_wdata_q <= dm_wdata;
            end else begin
              mem_addr_q  <= if_addr;
              mem_wr_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end
        end
        ARB_ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= ARB_DONE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (owner_q == OWN_DM) begin
              dm_done_q <= 1'b1;
              if (!mem_wr_q) dm_rdata_q <= mem_rdata;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        ARB_DONE: begin
          state_q   <= ARB_IDLE;
          if_done_q <= 1'b0;
          dm_done_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_w & ~rst;
  assign dm_gnt    = dm_gnt_w & ~rst;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
